param_control_unit: RTL and testbench

PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

---
 rtl/param_cu_pkg.sv | 32 +++
 rtl/param_cu_regfile.sv | 34 +++
 rtl/param_control_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_param_control_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_cu_pkg.sv
// Shared encodings for the parameterised control unit: instruction classes,
// FSM states, ALU opcodes and a width helper.
package param_cu_pkg;

   localparam int unsigned CLS_W    = 2;
   localparam int unsigned ALU_OP_W = 2;

   localparam logic [CLS_W-1:0] CLS_ALU   = 2'b00;
   localparam logic [CLS_W-1:0] CLS_LOAD  = 2'b01;
   localparam logic [CLS_W-1:0] CLS_STORE = 2'b10;
   localparam logic [CLS_W-1:0] CLS_MOVE  = 2'b11;

   // Opcodes are passed through untouched to the external ALU
   localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ALU_EXEC = 3'd1,
      ALU_WB   = 3'd2,
      LD_WAIT  = 3'd3,
      LD_WB    = 3'd4,
      ST_DONE  = 3'd5
   } cu_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/param_cu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// async active-low reset to zero and a flat view of all registers.
module param_cu_regfile #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned RSW      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [RSW-1:0]               ra_addr_i,
   output logic [DATA_W-1:0]            ra_data_o,
   input  logic [RSW-1:0]               rb_addr_i,
   output logic [DATA_W-1:0]            rb_data_o,
   input  logic                         we_i,
   input  logic [RSW-1:0]               waddr_i,
   input  logic [DATA_W-1:0]            wdata_i,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat_o
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign ra_data_o   = regs_q[ra_addr_i];
   assign rb_data_o   = regs_q[rb_addr_i];
   assign regs_flat_o = regs_q;

endmodule

// File: rtl/param_control_unit.sv
// Multi-cycle control unit sequencing ALU, load, store and move instructions
// over a small register file. Define CU_FLAGS_EN to add zero/negative flags.
module param_control_unit
   import param_cu_pkg::*;
#(
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned NUM_REGS = 4,
   parameter  int unsigned ADDR_W   = 4,
   parameter  int unsigned RAM_LAT  = 2,
   localparam int unsigned RSW      = $clog2(NUM_REGS),
   localparam int unsigned OPW      = max_u(RSW, ADDR_W),
   localparam int unsigned INSTR_W  = 4 + RSW + OPW
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [INSTR_W-1:0]          instr,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        ram_rd,
   output logic                        ram_wr,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   input  logic [DATA_W-1:0]           ram_rdata,
   output logic [DATA_W-1:0]           alu_a,
   output logic [DATA_W-1:0]           alu_b,
   output logic [ALU_OP_W-1:0]         alu_op,
   input  logic [DATA_W-1:0]           alu_result,
   output logic [NUM_REGS*DATA_W-1:0]  regs_flat,
   output logic                        flag_z,
   output logic                        flag_n
);

   // Load wait counter covers the RAM_LAT-1 cycles spent in LD_WAIT/LD_WB
   localparam int unsigned CNT_W = (RAM_LAT > 2) ? $clog2(RAM_LAT - 1) : 1;

   logic [CLS_W-1:0]    cls_c;
   logic [ALU_OP_W-1:0] op_c;
   logic [RSW-1:0]      rd_c;
   logic [RSW-1:0]      src_c;
   logic [OPW-1:0]      operand_c;

   assign cls_c     = instr[INSTR_W-1 -: CLS_W];
   assign op_c      = instr[INSTR_W-1-CLS_W -: ALU_OP_W];
   assign rd_c      = instr[OPW +: RSW];
   assign operand_c = instr[OPW-1:0];
   assign src_c     = operand_c[RSW-1:0];

   cu_state_e           state_q,     state_d;
   logic [RSW-1:0]      rd_q,        rd_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic                ram_rd_q,    ram_rd_d;
   logic                ram_wr_q,    ram_wr_d;
   logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
   logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
   logic [ALU_OP_W-1:0] alu_op_q,    alu_op_d;
   logic                done_q,      done_d;

   logic                we_c;
   logic [RSW-1:0]      waddr_c;
   logic [DATA_W-1:0]   wdata_c;
   logic [DATA_W-1:0]   ra_data_c;
   logic [DATA_W-1:0]   rb_data_c;

   param_cu_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .RSW      (RSW)
   ) u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .ra_addr_i   (rd_c),
      .ra_data_o   (ra_data_c),
      .rb_addr_i   (src_c),
      .rb_data_o   (rb_data_c),
      .we_i        (we_c),
      .waddr_i     (waddr_c),
      .wdata_i     (wdata_c),
      .regs_flat_o (regs_flat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_q        <= '0;
         cnt_q       <= '0;
         ram_rd_q    <= 1'b0;
         ram_wr_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         ram_rd_q    <= ram_rd_d;
         ram_wr_q    <= ram_wr_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         done_q      <= done_d;
      end
   end

   // Next-state, strobe and register-write decode
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      ram_rd_d    = ram_rd_q;
      ram_wr_d    = ram_wr_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      done_d      = 1'b0;
      we_c        = 1'b0;
      waddr_c     = rd_q;
      wdata_c     = alu_result;

      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               case (cls_c)
                  CLS_ALU: begin
                     alu_op_d = op_c;
                     alu_a_d  = ra_data_c;
                     alu_b_d  = rb_data_c;
                     rd_d     = rd_c;
                     state_d  = ALU_EXEC;
                  end
                  CLS_LOAD: begin
                     ram_rd_d   = 1'b1;
                     ram_addr_d = operand_c[ADDR_W-1:0];
                     rd_d       = rd_c;
                     if (RAM_LAT == 1) begin
                        state_d = LD_WB;
                     end else begin
                        cnt_d   = CNT_W'(RAM_LAT - 2);
                        state_d = LD_WAIT;
                     end
                  end
                  CLS_STORE: begin
                     ram_wr_d    = 1'b1;
                     ram_addr_d  = operand_c[ADDR_W-1:0];
                     ram_wdata_d = ra_data_c;
                     state_d     = ST_DONE;
                  end
                  CLS_MOVE: begin
                     we_c    = 1'b1;
                     waddr_c = rd_c;
                     wdata_c = rb_data_c;
                     done_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ALU_EXEC: begin
            state_d = ALU_WB;
         end
         ALU_WB: begin
            we_c    = 1'b1;
            wdata_c = alu_result;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         LD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = LD_WB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LD_WB: begin
            we_c     = 1'b1;
            wdata_c  = ram_rdata;
            ram_rd_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         ST_DONE: begin
            ram_wr_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            ram_rd_d = 1'b0;
            ram_wr_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

`ifdef CU_FLAGS_EN
   logic flag_z_q, flag_z_d;
   logic flag_n_q, flag_n_d;

   // Flags track the value of every register write; stores leave them alone
   always_comb begin
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      if (we_c) begin
         flag_z_d = (wdata_c == '0);
         flag_n_d = wdata_c[DATA_W-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
`else
   assign flag_z = 1'b0;
   assign flag_n = 1'b0;
`endif

   assign instr_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign ram_rd      = ram_rd_q;
   assign ram_wr      = ram_wr_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_param_control_unit.sv
// Directed bench for param_control_unit: a default 8-bit instance and a
// 16-bit/8-register/RAM_LAT=4 instance, checked against a scoreboard model.
module tb_param_control_unit;

`ifdef CU_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   localparam logic [1:0] C_ALU = 2'b00, C_LD = 2'b01, C_ST = 2'b10, C_MV = 2'b11;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: defaults
   logic [9:0]  a_instr;
   logic        a_valid, a_ready, a_busy, a_done, a_ram_rd, a_ram_wr, a_fz, a_fn;
   logic [3:0]  a_ram_addr;
   logic [7:0]  a_ram_wdata, a_ram_rdata, a_alu_a, a_alu_b, a_alu_result;
   logic [1:0]  a_alu_op;
   logic [31:0] a_regs;

   // Instance B: 16-bit, 8 registers, RAM_LAT=4
   logic [10:0]  b_instr;
   logic         b_valid, b_ready, b_busy, b_done, b_ram_rd, b_ram_wr, b_fz, b_fn;
   logic [3:0]   b_ram_addr;
   logic [15:0]  b_ram_wdata, b_ram_rdata, b_alu_a, b_alu_b, b_alu_result;
   logic [1:0]   b_alu_op;
   logic [127:0] b_regs;

   param_control_unit dut_a (
      .clk(clk), .rst_n(rst_n), .instr(a_instr), .instr_valid(a_valid),
      .instr_ready(a_ready), .busy(a_busy), .done(a_done),
      .ram_rd(a_ram_rd), .ram_wr(a_ram_wr), .ram_addr(a_ram_addr),
      .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
      .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_op(a_alu_op), .alu_result(a_alu_result),
      .regs_flat(a_regs), .flag_z(a_fz), .flag_n(a_fn)
   );

   param_control_unit #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(4), .RAM_LAT(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .instr(b_instr), .instr_valid(b_valid),
      .instr_ready(b_ready), .busy(b_busy), .done(b_done),
      .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr),
      .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
      .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_op(b_alu_op), .alu_result(b_alu_result),
      .regs_flat(b_regs), .flag_z(b_fz), .flag_n(b_fn)
   );

   function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
      case (op)
         2'b00:   return x + y;
         2'b01:   return x | y;
         2'b10:   return x & y;
         default: return x ^ y;
      endcase
   endfunction

   function automatic logic [7:0] mem_a(input logic [3:0] ad);
      case (ad)
         4'h0:    return 8'h55;
         4'h1:    return 8'hAA;
         4'h7:    return 8'h3C;
         default: return {4'hC, ad};
      endcase
   endfunction

   function automatic logic [15:0] mem_b(input logic [3:0] ad);
      case (ad)
         4'h3:    return 16'h8000;
         4'h5:    return 16'h1234;
         default: return {12'h0F0, ad};
      endcase
   endfunction

   // RAM models: data valid only in the cycle before the latency-th edge
   int a_rd_cnt = 0;
   int b_rd_cnt = 0;
   logic [3:0] st_addr = '0;
   logic [7:0] st_data = '0;

   always @(posedge clk) begin
      a_rd_cnt <= a_ram_rd ? a_rd_cnt + 1 : 0;
      b_rd_cnt <= b_ram_rd ? b_rd_cnt + 1 : 0;
      if (a_ram_wr) begin
         st_addr <= a_ram_addr;
         st_data <= a_ram_wdata;
      end
   end

   assign a_ram_rdata  = (a_ram_rd && a_rd_cnt == 1) ? mem_a(a_ram_addr) : 8'hEE;
   assign b_ram_rdata  = (b_ram_rd && b_rd_cnt == 3) ? mem_b(b_ram_addr) : 16'hEEEE;
   assign a_alu_result = 8'(alu_fn(a_alu_op, 16'(a_alu_a), 16'(a_alu_b)));
   assign b_alu_result = alu_fn(b_alu_op, b_alu_a, b_alu_b);

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct { bit wr; int rd; logic [15:0] val; } exp_t;
   typedef struct { logic [1:0] cls; int rd; int opnd; } bi_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   logic [7:0]  ma [4];
   logic [15:0] mb [8];

   task automatic a_issue(input logic [1:0] cls, input logic [1:0] op, input int rd,
                          input int opnd);
      exp_t e;
      int   n;
      a_instr = {cls, op, 2'(rd), 4'(opnd)};
      a_valid = 1'b1;
      n = 0;
      while (!a_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_accept", 32'(a_ready), 32'd1);
      e.wr = (cls != C_ST);
      e.rd = rd;
      case (cls)
         C_ALU:   e.val = 16'(8'(alu_fn(op, 16'(ma[2'(rd)]), 16'(ma[2'(opnd)]))));
         C_LD:    e.val = 16'(mem_a(4'(opnd)));
         C_ST:    e.val = 16'(ma[2'(rd)]);
         default: e.val = 16'(ma[2'(opnd)]);
      endcase
      if (e.wr) ma[2'(rd)] = 8'(e.val);
      sb_a.push_back(e);
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   task automatic a_wait_done(output int lat, output int rd_cyc, output int wr_cyc);
      exp_t e;
      bit   both;
      both = 1'b0;
      lat = 0; rd_cyc = 0; wr_cyc = 0;
      while (!a_done && lat < 40) begin
         if (a_ram_rd) rd_cyc++;
         if (a_ram_wr) wr_cyc++;
         if (a_ram_rd && a_ram_wr) both = 1'b1;
         @(negedge clk);
         lat++;
      end
      check("a_done_seen", 32'(a_done), 32'd1);
      check("a_rd_wr_exclusive", 32'(both), 32'd0);
      check("a_idle_strobes", {30'd0, a_ram_rd, a_ram_wr}, 32'd0);
      check("a_ready_at_done", 32'(a_ready), 32'd1);
      check("a_sb_pending", 32'(sb_a.size() > 0), 32'd1);
      if (sb_a.size() > 0) begin
         e = sb_a.pop_front();
         if (e.wr) check("a_reg_wb", 32'(a_regs[e.rd*8 +: 8]), 32'(e.val[7:0]));
         else      check("a_store_data", 32'(st_data), 32'(e.val[7:0]));
      end
      @(negedge clk);
      check("a_done_single", 32'(a_done), 32'd0);
   endtask

   task automatic b_push(input bi_t s);
      exp_t e;
      e.wr  = 1'b1;
      e.rd  = s.rd;
      e.val = (s.cls == C_LD) ? mem_b(4'(s.opnd)) : mb[3'(s.opnd)];
      mb[3'(s.rd)] = e.val;
      sb_b.push_back(e);
   endtask

   task automatic b_pop_check();
      exp_t e;
      check("b_sb_pending", 32'(sb_b.size() > 0), 32'd1);
      if (sb_b.size() > 0) begin
         e = sb_b.pop_front();
         check("b_reg_wb", 32'(b_regs[e.rd*16 +: 16]), 32'(e.val));
         check("b_flag_z", 32'(b_fz), 32'(FLAGS_ON && (e.val == 16'h0)));
         check("b_flag_n", 32'(b_fn), 32'(FLAGS_ON && e.val[15]));
      end
   endtask

   task automatic b_issue(input bi_t s);
      int n;
      b_instr = {s.cls, 2'b00, 3'(s.rd), 4'(s.opnd)};
      b_valid = 1'b1;
      n = 0;
      while (!b_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("b_accept", 32'(b_ready), 32'd1);
      b_push(s);
      @(negedge clk);
      b_valid = 1'b0;
   endtask

   task automatic b_wait_done(output int lat);
      lat = 0;
      while (!b_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("b_done_seen", 32'(b_done), 32'd1);
      if (b_done) b_pop_check();
      @(negedge clk);
      check("b_done_single", 32'(b_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, rdc, wrc, k, t0, tl;
      bit   fin;
      bi_t  s;
      bi_t  seq [6];

      rst_n   = 1'b0;
      a_instr = '0; a_valid = 1'b0;
      b_instr = '0; b_valid = 1'b0;
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;

      @(negedge clk);
      @(negedge clk);
      check("rst_a_regs", a_regs, 32'd0);
      check("rst_a_strobes", {28'd0, a_ram_rd, a_ram_wr, a_done, a_busy}, 32'd0);
      check("rst_a_alu", {14'd0, a_alu_op, a_alu_a, a_alu_b}, 32'd0);
      check("rst_a_ram_bus", {20'd0, a_ram_addr, a_ram_wdata}, 32'd0);
      check("rst_flags", {28'd0, a_fz, a_fn, b_fz, b_fn}, 32'd0);
      check("rst_b_regs", 32'(b_regs == '0), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("a_ready_after_rst", {30'd0, a_ready, a_busy}, 32'd2);

      // reg1=0x55 and reg2=0xAA through reg0
      a_issue(C_LD, 2'b00, 0, 0);  a_wait_done(lat, rdc, wrc);
      a_issue(C_MV, 2'b00, 1, 0);  a_wait_done(lat, rdc, wrc);
      check("a_move_latency", 32'(lat), 32'd0);
      a_issue(C_LD, 2'b00, 0, 1);  a_wait_done(lat, rdc, wrc);
      a_issue(C_MV, 2'b00, 2, 0);  a_wait_done(lat, rdc, wrc);
      check("a_reg1_init", 32'(a_regs[15:8]), 32'h55);
      check("a_reg2_init", 32'(a_regs[23:16]), 32'hAA);

      a_issue(C_ALU, 2'b01, 1, 2);
      check("a_alu_operands", {14'd0, a_alu_op, a_alu_a, a_alu_b}, {14'd0, 2'b01, 8'h55, 8'hAA});
      check("a_busy_alu", {30'd0, a_ready, a_busy}, 32'd1);
      a_wait_done(lat, rdc, wrc);
      check("a_alu_latency", 32'(lat), 32'd2);
      check("a_reg1_alu", 32'(a_regs[15:8]), 32'hFF);

      a_issue(C_LD, 2'b00, 3, 7);
      check("a_load_addr", {27'd0, a_ram_rd, a_ram_addr}, {27'd0, 1'b1, 4'h7});
      a_wait_done(lat, rdc, wrc);
      check("a_load_rd_cycles", 32'(rdc), 32'd2);
      check("a_load_latency", 32'(lat), 32'd2);
      check("a_reg3_load", 32'(a_regs[31:24]), 32'h3C);

      a_issue(C_ST, 2'b00, 2, 15);
      check("a_store_bus", {19'd0, a_ram_wr, a_ram_addr, a_ram_wdata}, {19'd0, 1'b1, 4'hF, 8'hAA});
      a_wait_done(lat, rdc, wrc);
      check("a_store_wr_cycles", 32'(wrc), 32'd1);
      check("a_store_rd_cycles", 32'(rdc), 32'd0);
      check("a_store_addr", 32'(st_addr), 32'hF);

      // rd equal to source: both operands see the pre-write value, full-width wrap
      a_issue(C_ALU, 2'b00, 2, 2);
      check("a_alu_same_src", {16'd0, a_alu_a, a_alu_b}, 32'hAAAA);
      a_wait_done(lat, rdc, wrc);
      check("a_reg2_wrap", 32'(a_regs[23:16]), 32'h54);

      // Reset while the load waits on RAM
      a_issue(C_LD, 2'b00, 1, 7);
      check("a_ldwait_rd", 32'(a_ram_rd), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("a_rst_drops_rd", {30'd0, a_ram_rd, a_done}, 32'd0);
      @(negedge clk);
      check("a_rst_no_done", 32'(a_done), 32'd0);
      check("a_rst_regs", a_regs, 32'd0);
      foreach (ma[i]) ma[i] = '0;
      sb_a.delete();
      rst_n = 1'b1;
      @(negedge clk);
      check("a_ready_post_rst", {30'd0, a_ready, a_done}, 32'd2);
      a_issue(C_LD, 2'b00, 1, 7);
      a_wait_done(lat, rdc, wrc);
      check("a_load_after_rst", a_regs, 32'h0000_3C00);

      // Wide instance: flags, move of zero, back-to-back accepts
      s = '{cls: C_LD, rd: 7, opnd: 3};
      b_issue(s);
      b_wait_done(lat);
      check("b_load_latency", 32'(lat), 32'd4);
      s = '{cls: C_MV, rd: 7, opnd: 0};
      b_issue(s);
      b_wait_done(lat);
      check("b_reg7_zero", 32'(b_regs[127:112]), 32'd0);

      seq[0] = '{cls: C_LD, rd: 1, opnd: 3};
      seq[1] = '{cls: C_MV, rd: 2, opnd: 1};
      seq[2] = '{cls: C_MV, rd: 3, opnd: 2};
      seq[3] = '{cls: C_LD, rd: 4, opnd: 5};
      seq[4] = '{cls: C_MV, rd: 5, opnd: 4};
      seq[5] = '{cls: C_MV, rd: 7, opnd: 0};
      k = 0; t0 = 0; tl = 0; fin = 1'b0;
      b_instr = {seq[0].cls, 2'b00, 3'(seq[0].rd), 4'(seq[0].opnd)};
      b_valid = 1'b1;
      for (int c = 0; c < 200 && !fin; c++) begin
         if (b_done) begin
            b_pop_check();
            if (k == 6 && sb_b.size() == 0) begin
               tl  = cyc;
               fin = 1'b1;
            end
         end
         if (!fin && k < 6 && b_ready) begin
            if (k == 0) t0 = cyc + 1;
            b_push(seq[k]);
            k++;
         end
         if (!fin) begin
            @(negedge clk);
            if (k < 6) b_instr = {seq[k].cls, 2'b00, 3'(seq[k].rd), 4'(seq[k].opnd)};
            else       b_valid = 1'b0;
         end
      end
      b_valid = 1'b0;
      check("b_b2b_all_done", 32'(fin), 32'd1);
      check("b_b2b_cycles", 32'(tl - t0 + 1), 32'd14);
      check("b_reg3", 32'(b_regs[63:48]), 32'h8000);
      check("b_reg5", 32'(b_regs[95:80]), 32'h1234);

      @(negedge clk);
      check("sb_drained", 32'(sb_a.size() + sb_b.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
